// File: rtl/onehot_to_bin_reg_pkg.sv
// Shared helpers for the one-hot to binary encoder slice.
// Holds the index-width function used to size the bin output.
package onehot_to_bin_reg_pkg;

    // Index width for an n-bit one-hot vector, never below 1.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/onehot_to_bin_comb.sv
// Combinational one-hot to binary encoder with validity check.
// Ports: onehot_i (vector in), bin_o (index of lowest set bit), err_o (not exactly one-hot).
module onehot_to_bin_comb
    import onehot_to_bin_reg_pkg::*;
#(
    parameter  int ONEHOT_WIDTH = 8,
    localparam int BIN_WIDTH    = clog2_min1(ONEHOT_WIDTH)
) (
    input  logic [ONEHOT_WIDTH-1:0] onehot_i,
    output logic [BIN_WIDTH-1:0]    bin_o,
    output logic                    err_o
);

    generate
        if (ONEHOT_WIDTH < 2) begin : g_width_chk
            $fatal(1, "onehot_to_bin_comb: ONEHOT_WIDTH must be at least 2");
        end
    endgenerate

    logic [ONEHOT_WIDTH-1:0] low;
    logic [ONEHOT_WIDTH-1:0] rest;

    // Isolating the lowest set bit leaves a legal one-hot vector unchanged,
    // so one OR encoder serves both the legal and the error case.
    assign low  = onehot_i & (~onehot_i + ONEHOT_WIDTH'(1));
    assign rest = onehot_i & (onehot_i - ONEHOT_WIDTH'(1));

    assign err_o = (onehot_i == '0) || (rest != '0);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            if (low[i]) begin
                bin_o = bin_o | BIN_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/onehot_to_bin_reg.sv
// Registered one-hot to binary encoder, one cycle of latency.
// Ports: clk_i, rst_i, valid_i, onehot_i in; valid_o, bin_o, err_o out.
module onehot_to_bin_reg
    import onehot_to_bin_reg_pkg::*;
#(
    parameter  int ONEHOT_WIDTH = 8,
    localparam int BIN_WIDTH    = clog2_min1(ONEHOT_WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic [ONEHOT_WIDTH-1:0] onehot_i,
    output logic                    valid_o,
    output logic [BIN_WIDTH-1:0]    bin_o,
    output logic                    err_o
);

    logic [BIN_WIDTH-1:0] bin_c;
    logic                 err_c;

    onehot_to_bin_comb #(
        .ONEHOT_WIDTH(ONEHOT_WIDTH)
    ) u_comb (
        .onehot_i(onehot_i),
        .bin_o   (bin_c),
        .err_o   (err_c)
    );

    // Data registers only load on valid samples, so idle cycles hold the last result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            bin_o   <= '0;
            err_o   <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                bin_o <= bin_c;
                err_o <= err_c;
            end
        end
    end

endmodule

// File: tb/tb_onehot_to_bin_reg.sv
// Self-checking bench for onehot_to_bin_reg at widths 8 and 5.
// Table vectors plus reset and valid-gap sequences, checked via a scoreboard queue.
module tb_onehot_to_bin_reg;

    typedef struct {
        logic       v;
        logic [7:0] oh;
        logic [2:0] b;
        logic       e;
    } vec_t;

    typedef struct {
        logic       v;
        logic [2:0] b;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_i = 1'b0;
    logic [7:0] onehot_i = '0;
    logic       valid_o;
    logic [2:0] bin_o;
    logic       err_o;

    logic       valid5_i = 1'b0;
    logic [4:0] onehot5_i = '0;
    logic       valid5_o;
    logic [2:0] bin5_o;
    logic       err5_o;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    onehot_to_bin_reg #(.ONEHOT_WIDTH(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_i),
        .onehot_i(onehot_i),
        .valid_o (valid_o),
        .bin_o   (bin_o),
        .err_o   (err_o)
    );

    onehot_to_bin_reg #(.ONEHOT_WIDTH(5)) dut5 (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid5_i),
        .onehot_i(onehot5_i),
        .valid_o (valid5_o),
        .bin_o   (bin5_o),
        .err_o   (err5_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, " valid_o"}, int'(valid_o), int'(e.v));
        chk({tag, " bin_o"}, int'(bin_o), int'(e.b));
        chk({tag, " err_o"}, int'(err_o), int'(e.e));
    endtask

    // Reference: position of the lowest set bit by linear search.
    function automatic logic [2:0] ref_idx(input logic [7:0] x);
        for (int i = 0; i < 8; i++) begin
            if (x[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic drive(input string tag, input logic v, input logic [7:0] oh,
                         input logic [2:0] b, input logic e);
        exp_t ex;
        @(negedge clk);
        valid_i  = v;
        onehot_i = oh;
        ex.v = v;
        ex.b = b;
        ex.e = e;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            chk_out(tag, sb.pop_front());
        end
    endtask

    task automatic drive5(input logic [4:0] oh, input logic [2:0] b, input logic e);
        @(negedge clk);
        valid5_i  = 1'b1;
        onehot5_i = oh;
        @(posedge clk);
        #1;
        chk("w5 valid_o", int'(valid5_o), 1);
        chk("w5 bin_o", int'(bin5_o), int'(b));
        chk("w5 err_o", int'(err5_o), int'(e));
    endtask

    initial begin
        exp_t z;
        logic [7:0] r;
        logic [2:0] ri;

        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, 8'(1 << i), 3'(i), 1'b0};
        end
        tbl[8]  = '{1'b1, 8'h00,        3'd0, 1'b1};
        tbl[9]  = '{1'b1, 8'b0010_0100, 3'd2, 1'b1};
        tbl[10] = '{1'b1, 8'hFF,        3'd0, 1'b1};
        tbl[11] = '{1'b1, 8'b0001_0000, 3'd4, 1'b0};
        tbl[12] = '{1'b0, 8'b0000_0010, 3'd4, 1'b0};
        tbl[13] = '{1'b0, 8'b1000_0000, 3'd4, 1'b0};
        tbl[14] = '{1'b1, 8'b1100_0000, 3'd6, 1'b1};
        tbl[15] = '{1'b1, 8'b0000_0010, 3'd1, 1'b0};

        z.v = 1'b0;
        z.b = 3'd0;
        z.e = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid_i  = 1'b1;
            onehot_i = 8'($urandom);
            @(posedge clk);
            #1;
            chk_out("reset hold", z);
        end
        @(negedge clk);
        valid_i = 1'b0;
        rst     = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive($sformatf("tbl%0d", i), tbl[i].v, tbl[i].oh, tbl[i].b, tbl[i].e);
        end

        for (int i = 0; i < 20; i++) begin
            r  = 8'(1 << $urandom_range(7, 0));
            ri = ref_idx(r);
            drive($sformatf("rand%0d", i), 1'b1, r, ri, 1'b0);
        end

        // Asynchronous reset between edges, with a sample in flight.
        @(negedge clk);
        valid_i  = 1'b1;
        onehot_i = 8'h08;
        #1;
        rst = 1'b1;
        #1;
        chk_out("async rst", z);
        @(posedge clk);
        #1;
        chk_out("rst inflight", z);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();

        // First edge after reset release samples normally.
        drive("post rst", 1'b1, 8'h20, 3'd5, 1'b0);
        drive("idle hold", 1'b0, 8'h01, 3'd5, 1'b0);

        for (int i = 0; i < 5; i++) begin
            drive5(5'(1 << i), 3'(i), 1'b0);
        end
        drive5(5'b11000, 3'd3, 1'b1);
        drive5(5'b00000, 3'd0, 1'b1);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_to_bin_reg.md
# onehot_to_bin_reg

Registered, parameterizable one-hot to binary encoder with one-hot validity checking. Converts an ONEHOT_WIDTH-bit one-hot vector into its bit index and flags zero-hot or multi-hot inputs. Used wherever grant, select or state vectors must be re-encoded as indices, such as arbiter grants to mux selects. One cycle of latency, in a single clock domain.

## Interface
Parameters:
- ONEHOT_WIDTH, default 8: input vector width; legal range ≥ 2.
- BIN_WIDTH, default $clog2(ONEHOT_WIDTH): output index width; derived, not overridden.

Ports:
- clk_i, input, 1: clock; all state updates on the rising edge.
- rst_i, input, 1: reset; asynchronous, active-high.
- valid_i, input, 1: onehot_i carries a sample this cycle.
- onehot_i, input, ONEHOT_WIDTH: one-hot input vector.
- valid_o, output, 1: registered copy of valid_i; bin_o and err_o are meaningful when high.
- bin_o, output, BIN_WIDTH: index of the set bit in onehot_i.
- err_o, output, 1: the sampled input was not exactly one-hot (zero bits set or more than one bit set).

## Operation
- Encoding: bin_o = i when onehot_i[i] is the only set bit. For ONEHOT_WIDTH=8: 8'b0000_0001→0, 8'b0000_1000→3, 8'b1000_0000→7.
- The encoder is OR-based: bin_o[k] = OR of onehot_i[i] over all i whose bit k is set. No priority chain is used.
- Validity check: err = (onehot_i == 0) OR (more than one bit set). Multi-hot detection uses the (x & (x-1)) != 0 form or an equivalent reduction.
- Invalid input:
  - err_o = 1.
  - bin_o = index of the lowest set bit, so the output is deterministic. Lowest-set-bit selection applies only when err is 1.
  - For zero input, bin_o = 0.
- When ONEHOT_WIDTH is not a power of two, input bit indices at or above ONEHOT_WIDTH do not exist. bin_o never exceeds ONEHOT_WIDTH-1.
- When valid_i = 0: valid_o drops to 0 on the next edge, and bin_o/err_o hold their previous values (registers enabled by valid_i).

## Timing
- Latency: 1 cycle. Inputs sampled on edge N appear on valid_o/bin_o/err_o after edge N.
- Throughput: one sample per cycle; back-to-back valid_i is supported with no bubbles.
- Reset (asynchronous assert, synchronous-safe deassert): valid_o=0, bin_o=0, err_o=0, held while rst_i=1.
- The first edge after rst_i falls samples normally.
- If rst_i asserts mid-stream, the in-flight sample is discarded, with no partial output.
- No backpressure: the downstream block must accept every valid_o cycle.

## Structure
- Shared package: none required.
  - BIN_WIDTH is computed locally as a localparam-style derived parameter.
  - If the codebase keeps a common utilities package, add a clog2-with-minimum-1 function there.
- Natural sub-module: onehot_to_bin_comb, a purely combinational encoder plus error detector (onehot_i → bin, err). The top level adds the valid pipeline register and reset.
- Place an elaboration-time check that fails when ONEHOT_WIDTH < 2.

## Test plan
- Reset: hold rst_i=1 with random inputs → valid_o=0, bin_o=0, err_o=0. Assert rst_i asynchronously between edges → outputs clear immediately.
- Exhaustive legal sweep (ONEHOT_WIDTH=8): valid_i=1 with 1<<i for i=0..7 back-to-back → bin_o=i and err_o=0 one cycle later, valid_o=1 every cycle.
- 20 randomized one-hot vectors with valid_i=1 → bin_o equals the index of the set bit, err_o=0. Compare against a reference model each cycle.
- Invalid inputs:
  - 8'h00 → err_o=1, bin_o=0.
  - 8'b0010_0100 → err_o=1, bin_o=2.
  - 8'hFF → err_o=1, bin_o=0.
- Valid gaps: 8'b0001_0000 with valid_i=1, then valid_i=0 with 8'b0000_0010 → valid_o=1,bin_o=4, then valid_o=0 with bin_o still 4.
- Non-power-of-two width (ONEHOT_WIDTH=5, BIN_WIDTH=3): inputs 1<<0..1<<4 → bin_o=0..4, err_o=0.
